trap_controller: RTL and testbench
==================================

# trap_controller

Machine-mode trap sequencer between the writeback stage and fetch. It owns the trap CSRs (mstatus.MIE/MPIE, mie, mtvec, mepc, mcause) and masks raw interrupt lines into the `sip`/`tip`/`eip` inputs of writeback. On a writeback trap or retiring `mret` it updates CSR state, flushes the pipeline for one cycle, then holds a redirect to fetch until fetch accepts it.

## Interface
- No parameters; widths are fixed for RV32.
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `traped` in 1: writeback takes a trap this cycle.
- `ecause` in 4: cause code from writeback.
- `interupt` in 1: the trap is an interrupt.
- `ecp` in 32: PC of the trapping instruction.
- `mret` in 1: an `mret` retires in writeback this cycle (valid, not trapped).
- `msip_raw`, `mtip_raw`, `meip_raw` in 1 each: raw pending sources.
- `csr_we` in 1, `csr_waddr` in 12, `csr_wdata` in 32: CSR write port.
- `csr_raddr` in 12, `csr_rdata` out 32: combinational read port.
- `sip`, `tip`, `eip` out 1 each: masked interrupts to writeback.
- `flush` out 1: kill all in-flight pipeline instructions.
- `redirect_valid` out 1, `redirect_ready` in 1, `redirect_pc` out 32: fetch redirect handshake.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Interrupt masking, IDLE only: `eip = meip_raw & mie[11] & MIE`, `tip = mtip_raw & mie[7] & MIE`, `sip = msip_raw & mie[3] & MIE`. All three are forced to 0 when not IDLE.
- CSR map (other addresses read 0; writes to them are ignored):
  - 0x300 mstatus: only bit 3 MIE and bit 7 MPIE are writable; all other bits read 0.
  - 0x304 mie: bits 3, 7 and 11 are writable.
  - 0x305 mtvec.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause.
- Trap in IDLE:
  - mepc ← `ecp & ~3`.
  - mcause ← `{interupt, 27'b0, ecause}`.
  - MPIE ← MIE, then MIE ← 0.
  - Target ← `{mtvec[31:2], 2'b00}`.
  - Next state FLUSH.
- `mret` in IDLE (no `traped`): MIE ← MPIE, MPIE ← 1, target ← mepc, next state FLUSH.
- FSM:
  - IDLE → FLUSH on trap or mret.
  - FLUSH → REDIRECT unconditionally; `flush` = 1 for exactly this one cycle.
  - REDIRECT holds `redirect_valid` = 1 and a stable `redirect_pc`; → IDLE on the cycle with `redirect_ready` = 1.
- `traped` and `mret` are ignored outside IDLE. Writeback is already flushed, so neither can legally occur there.

## Timing
- Reset values: all CSRs 0, state IDLE. `flush`, `redirect_valid`, `busy`, `sip`, `tip`, `eip` and `redirect_pc` are all 0.
- CSR writes take effect at the next edge. `csr_rdata` is combinational from current state, with no bypass of a same-cycle write.
- Trap or mret seen at cycle N:
  - CSRs are updated at edge N.
  - `flush` = 1 during N+1.
  - `redirect_valid` = 1 from N+2. Minimum redirect latency is 2 cycles.
- Simultaneous events:
  - `traped` and `mret` together: the trap wins and `mret` has no effect.
  - `traped` and `csr_we` together, both targeting mstatus/mepc/mcause: the trap update wins.
  - `csr_we` to mie or mtvec is still applied. The redirect uses the pre-write mtvec.
- `csr_we` outside IDLE is applied normally. `redirect_pc` is already latched and does not change.
- Reset asserted mid-sequence: immediate return to IDLE, and `redirect_valid` drops asynchronously.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - mtvec[1:0] is writable, with mode = mtvec[0].
  - An interrupt with mode 1 targets `{mtvec[31:2],2'b00} + 4*ecause`.
  - Exceptions always target the base.
- `TRAP_VECTORED_EN` undefined: mtvec[1:0] reads 0 and writes to those bits are ignored; all traps target the base.

## Structure
- Shared header `params.vh` holds:
  - CSR address constants: CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE.
  - FSM state encodings: TRAP_IDLE, TRAP_FLUSH, TRAP_REDIRECT.
  - Interrupt cause codes 3, 7, 11.
- One sub-module, `trap_csr_regs`, holds the CSR storage, the write decode with trap/mret priority, and the read mux. The top module holds the FSM, the masking logic and the target computation.

## Test plan
- Reset, then write mtvec = 0x100 and mstatus = 0x8. Pulse `traped` with ecause = 2, interupt = 0, ecp = 0x2004.
  - Required: mepc = 0x2004, mcause = 0x2, mstatus = 0x80.
  - Required: `flush` at N+1, redirect to 0x100 at N+2.
- MIE = 1, mie = 0x80, `mtip_raw` = 1 → `tip` = 1. Once busy, `tip` = 0. With mie = 0 → `tip` = 0.
- `mret` with mepc = 0x3000 and mstatus = 0x80 → mstatus = 0x88, redirect_pc = 0x3000.
- Hold `redirect_ready` = 0 for 5 cycles → `redirect_valid` and `redirect_pc` stay stable; IDLE is re-entered the cycle after ready.
- `traped` and `mret` together, and separately `traped` with a `csr_we` to mepc = 0x44 → trap semantics apply and mepc = ecp.
- With `TRAP_VECTORED_EN`: mtvec = 0x201, interrupt with ecause 7 → target 0x21C. Without the macro: target 0x200 and mtvec reads 0x200.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// sequencer state encodings and the interrupt cause codes (which double as
// the mie bit positions).
package trap_controller_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] TRAP_IDLE     = 2'd0;
    localparam logic [1:0] TRAP_FLUSH    = 2'd1;
    localparam logic [1:0] TRAP_REDIRECT = 2'd2;

    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // Byte offset of a vectored interrupt entry: 4 bytes per cause.
    function automatic logic [31:0] vector_offset(input logic [3:0] cause);
        return {26'b0, cause, 2'b00};
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Trap CSR storage (mstatus.MIE/MPIE, mie, mtvec, mepc, mcause), write decode
// with trap > mret > software-write priority, and the combinational read mux.
// Define TRAP_VECTORED_EN to make mtvec[1:0] writable (vectored mode).
module trap_csr_regs
    import trap_controller_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_i,
    input  logic        mret_i,
    input  logic        interrupt_i,
    input  logic [3:0]  ecause_i,
    input  logic [31:0] ecp_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic        mstatus_mie_o,
    output logic        msie_o,
    output logic        mtie_o,
    output logic        meie_o,
    output logic [31:0] mtvec_base_o,
    output logic        mtvec_mode_o,
    output logic [31:0] mepc_o
);

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MtvecMask = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MtvecMask = 32'hFFFF_FFFC;
`endif

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

    assign wr_mstatus = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
    assign wr_mie     = csr_we_i && (csr_waddr_i == CSR_MIE);
    assign wr_mtvec   = csr_we_i && (csr_waddr_i == CSR_MTVEC);
    assign wr_mepc    = csr_we_i && (csr_waddr_i == CSR_MEPC);
    assign wr_mcause  = csr_we_i && (csr_waddr_i == CSR_MCAUSE);

    // Next-state CSR values; trap and mret updates override software writes.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (trap_i) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie_d  = csr_wdata_i[3];
            mstatus_mpie_d = csr_wdata_i[7];
        end

        // mie and mtvec are never touched by the trap itself.
        if (wr_mie)   mie_d   = csr_wdata_i & MIE_MASK;
        if (wr_mtvec) mtvec_d = csr_wdata_i & MtvecMask;

        if (trap_i) begin
            mepc_d   = ecp_i & ~32'h3;
            mcause_d = {interrupt_i, 27'b0, ecause_i};
        end else begin
            if (wr_mepc)   mepc_d   = csr_wdata_i & ~32'h3;
            if (wr_mcause) mcause_d = csr_wdata_i;
        end
    end

    // CSR state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    // Combinational read port; unmapped addresses read zero.
    always_comb begin
        csr_rdata_o = 32'h0;
        case (csr_raddr_i)
            CSR_MSTATUS: csr_rdata_o = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            CSR_MIE:     csr_rdata_o = mie_q;
            CSR_MTVEC:   csr_rdata_o = mtvec_q;
            CSR_MEPC:    csr_rdata_o = mepc_q;
            CSR_MCAUSE:  csr_rdata_o = mcause_q;
            default:     csr_rdata_o = 32'h0;
        endcase
    end

    assign mstatus_mie_o = mstatus_mie_q;
    assign msie_o        = mie_q[IRQ_MSI];
    assign mtie_o        = mie_q[IRQ_MTI];
    assign meie_o        = mie_q[IRQ_MEI];
    assign mtvec_base_o  = {mtvec_q[31:2], 2'b00};
    assign mtvec_mode_o  = mtvec_q[0];
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: IDLE -> FLUSH (one-cycle pipeline kill) ->
// REDIRECT (hold fetch redirect until accepted). Also masks raw interrupts.
// Vectored interrupt targets are enabled by TRAP_VECTORED_EN (via mtvec mode,
// which always reads 0 when the macro is undefined).
module trap_controller
    import trap_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        traped,
    input  logic [3:0]  ecause,
    input  logic        interupt,
    input  logic [31:0] ecp,
    input  logic        mret,
    input  logic        msip_raw,
    input  logic        mtip_raw,
    input  logic        meip_raw,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        sip,
    output logic        tip,
    output logic        eip,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    logic [1:0]  state_q, state_d;
    logic [31:0] target_q, target_d;

    logic        idle, trap_take, mret_take;
    logic        mstatus_mie, msie, mtie, meie, mtvec_mode;
    logic [31:0] mtvec_base, mepc, trap_target;

    assign idle      = (state_q == TRAP_IDLE);
    assign trap_take = idle && traped;
    assign mret_take = idle && mret && !traped;

    trap_csr_regs u_csr (
        .clk_i         (clk),
        .rst_i         (reset),
        .trap_i        (trap_take),
        .mret_i        (mret_take),
        .interrupt_i   (interupt),
        .ecause_i      (ecause),
        .ecp_i         (ecp),
        .csr_we_i      (csr_we),
        .csr_waddr_i   (csr_waddr),
        .csr_wdata_i   (csr_wdata),
        .csr_raddr_i   (csr_raddr),
        .csr_rdata_o   (csr_rdata),
        .mstatus_mie_o (mstatus_mie),
        .msie_o        (msie),
        .mtie_o        (mtie),
        .meie_o        (meie),
        .mtvec_base_o  (mtvec_base),
        .mtvec_mode_o  (mtvec_mode),
        .mepc_o        (mepc)
    );

    // Trap target from the pre-write mtvec; only interrupts are vectored.
    always_comb begin
        trap_target = mtvec_base;
        if (interupt && mtvec_mode) trap_target = mtvec_base + vector_offset(ecause);
    end

    // Sequencer next state and redirect target latch.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            TRAP_IDLE: begin
                if (trap_take) begin
                    state_d  = TRAP_FLUSH;
                    target_d = trap_target;
                end else if (mret_take) begin
                    state_d  = TRAP_FLUSH;
                    target_d = mepc;
                end
            end
            TRAP_FLUSH:    state_d = TRAP_REDIRECT;
            TRAP_REDIRECT: if (redirect_ready) state_d = TRAP_IDLE;
            default:       state_d = TRAP_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= TRAP_IDLE;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign sip = idle && msip_raw && msie && mstatus_mie;
    assign tip = idle && mtip_raw && mtie && mstatus_mie;
    assign eip = idle && meip_raw && meie && mstatus_mie;

    assign flush          = (state_q == TRAP_FLUSH);
    assign redirect_valid = (state_q == TRAP_REDIRECT);
    assign redirect_pc    = target_q;
    assign busy           = !idle;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios followed by a
// randomized run, all checked against a word-level behavioural model.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        traped, interupt, mret;
    logic [3:0]  ecause;
    logic [31:0] ecp;
    logic        msip_raw, mtip_raw, meip_raw;
    logic        csr_we;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        sip, tip, eip, flush, redirect_valid, redirect_ready, busy;
    logic [31:0] redirect_pc;

    trap_controller dut (
        .clk            (clk),
        .reset          (reset),
        .traped         (traped),
        .ecause         (ecause),
        .interupt       (interupt),
        .ecp            (ecp),
        .mret           (mret),
        .msip_raw       (msip_raw),
        .mtip_raw       (mtip_raw),
        .meip_raw       (meip_raw),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .sip            (sip),
        .tip            (tip),
        .eip            (eip),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Model: architectural CSR words plus cycles-elapsed since the event
    // (0 = idle, 1 = flush cycle, 2 = waiting for fetch).
    bit [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_target;
    int        m_phase;

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_target = 0; m_phase = 0;
    endtask

    function automatic bit [31:0] model_read(input bit [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit        idle, tr, rt;
        bit [31:0] old_st, old_tvec, old_epc;
        idle = (m_phase == 0);
        tr = idle && traped;
        rt = idle && mret && !traped;
        old_st = m_mstatus; old_tvec = m_mtvec; old_epc = m_mepc;
        if (tr) m_mstatus = old_st[3] ? 32'h80 : 32'h0;
        else if (rt) m_mstatus = 32'h80 | (old_st[7] ? 32'h8 : 32'h0);
        else if (csr_we && csr_waddr == 12'h300) m_mstatus = csr_wdata & 32'h88;
        if (csr_we && csr_waddr == 12'h304) m_mie = csr_wdata & 32'h888;
        if (csr_we && csr_waddr == 12'h305) m_mtvec = VEC ? csr_wdata : (csr_wdata & ~32'h3);
        if (tr) begin
            m_mepc   = ecp & ~32'h3;
            m_mcause = (interupt ? 32'h8000_0000 : 32'h0) + 32'(ecause);
            m_target = (old_tvec & ~32'h3) + ((VEC && interupt && old_tvec[0]) ? 4 * ecause : 0);
        end else begin
            if (csr_we && csr_waddr == 12'h341) m_mepc = csr_wdata & ~32'h3;
            if (csr_we && csr_waddr == 12'h342) m_mcause = csr_wdata;
            if (rt) m_target = old_epc;
        end
        if (idle) m_phase = (tr || rt) ? 1 : 0;
        else if (m_phase == 1) m_phase = 2;
        else if (redirect_ready) m_phase = 0;
    endtask

    task automatic check_outputs();
        bit idle;
        idle = (m_phase == 0);
        check("busy", busy, m_phase != 0);
        check("flush", flush, m_phase == 1);
        check("redirect_valid", redirect_valid, m_phase == 2);
        check("sip", sip, idle && msip_raw && m_mie[3] && m_mstatus[3]);
        check("tip", tip, idle && mtip_raw && m_mie[7] && m_mstatus[3]);
        check("eip", eip, idle && meip_raw && m_mie[11] && m_mstatus[3]);
        check("csr_rdata", csr_rdata, model_read(csr_raddr));
        if (m_phase == 2) check("redirect_pc", redirect_pc, m_target);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        traped = 0; mret = 0; interupt = 0; ecause = 0; ecp = 0;
        csr_we = 0; csr_waddr = 0; csr_wdata = 0;
        msip_raw = 0; mtip_raw = 0; meip_raw = 0; redirect_ready = 0;
    endtask

    task automatic csr_write(input bit [11:0] a, input bit [31:0] d);
        csr_we = 1; csr_waddr = a; csr_wdata = d;
        step();
        csr_we = 0;
    endtask

    task automatic drain();
        redirect_ready = 1;
        repeat (3) step();
        redirect_ready = 0;
    endtask

    initial begin
        quiet();
        csr_raddr = 12'h300;
        reset = 1;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_flush", flush, 0);
        @(negedge clk);
        reset = 0;

        // Basic exception: ecause 2 at 0x2004 with mtvec 0x100.
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        traped = 1; ecause = 2; ecp = 32'h2004;
        step();
        traped = 0; csr_raddr = 12'h341;
        #1 check("n1_flush", flush, 1);
        check("n1_mepc", csr_rdata, 32'h2004);
        step();
        csr_raddr = 12'h342;
        #1 check("n2_valid", redirect_valid, 1);
        check("n2_pc", redirect_pc, 32'h100);
        check("n2_mcause", csr_rdata, 32'h2);
        redirect_ready = 1;
        step();
        redirect_ready = 0; csr_raddr = 12'h300;
        #1 check("n3_idle", busy, 0);
        check("n3_mstatus", csr_rdata, 32'h80);

        // Timer interrupt masking.
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h80);
        mtip_raw = 1;
        #1 check("tip_on", tip, 1);
        traped = 1; interupt = 1; ecause = 7; ecp = 32'h40;
        step();
        traped = 0; interupt = 0;
        #1 check("tip_busy", tip, 0);
        drain();
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h0);
        #1 check("tip_masked", tip, 0);
        mtip_raw = 0;

        // mret with a stalled fetch.
        csr_write(12'h341, 32'h3000);
        csr_write(12'h300, 32'h80);
        mret = 1;
        step();
        mret = 0; csr_raddr = 12'h300;
        #1 check("mret_mstatus", csr_rdata, 32'h88);
        step();
        for (int i = 0; i < 5; i++) begin
            #1 check("hold_valid", redirect_valid, 1);
            check("hold_pc", redirect_pc, 32'h3000);
            step();
        end
        redirect_ready = 1;
        step();
        redirect_ready = 0;
        #1 check("ready_idle", busy, 0);

        // Trap beats mret; trap beats csr write to mepc.
        traped = 1; mret = 1; ecause = 4; ecp = 32'h503;
        step();
        traped = 0; mret = 0; csr_raddr = 12'h341;
        #1 check("tm_mepc", csr_rdata, 32'h500);
        drain();
        traped = 1; ecp = 32'h600; csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h44;
        step();
        traped = 0; csr_we = 0;
        #1 check("tw_mepc", csr_rdata, 32'h600);
        drain();

        // Vectored target.
        csr_write(12'h305, 32'h201);
        csr_raddr = 12'h305;
        #1 check("mtvec_rd", csr_rdata, VEC ? 32'h201 : 32'h200);
        traped = 1; interupt = 1; ecause = 7; ecp = 32'h10;
        step();
        traped = 0; interupt = 0;
        step();
        #1 check("vec_pc", redirect_pc, VEC ? 32'h21C : 32'h200);

        // Reset mid-redirect drops redirect_valid without waiting for an edge.
        #2 reset = 1;
        #1 check("arst_valid", redirect_valid, 0);
        check("arst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            traped   = ($urandom_range(0, 9) == 0);
            mret     = ($urandom_range(0, 9) == 0);
            interupt = $urandom_range(0, 1);
            ecause   = 4'($urandom);
            ecp      = $urandom;
            msip_raw = $urandom_range(0, 1);
            mtip_raw = $urandom_range(0, 1);
            meip_raw = $urandom_range(0, 1);
            redirect_ready = $urandom_range(0, 1);
            csr_we   = ($urandom_range(0, 2) == 0);
            csr_wdata = $urandom;
            case ($urandom_range(0, 5))
                0: csr_waddr = 12'h300;
                1: csr_waddr = 12'h304;
                2: csr_waddr = 12'h305;
                3: csr_waddr = 12'h341;
                4: csr_waddr = 12'h342;
                default: csr_waddr = 12'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: csr_raddr = 12'h300;
                1: csr_raddr = 12'h304;
                2: csr_raddr = 12'h305;
                3: csr_raddr = 12'h341;
                4: csr_raddr = 12'h342;
                default: csr_raddr = 12'($urandom);
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
